// File: rtl/seq_mult_nxw.sv
// seq_mult_nxw: iterative radix-2 shift-add NxW multiplier with valid/ready handshakes
module seq_mult_nxw #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] multer,
  input  logic [W-1:0] multor,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N+W-1:0] result,
  output logic         busy
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [N+W-1:0] md, acc, sum;
  logic [N-1:0] mag_a;
  logic [W-1:0] mag_b, mr;
  logic [CW-1:0] cnt;
  logic neg, last;
  always_comb begin
    mag_a = (is_signed && multer[N-1]) ? -multer : multer;
    mag_b = (is_signed && multor[W-1]) ? -multor : multor;
    sum = acc + (mr[0] ? md : '0);
    last = cnt == CW'(W - 1);
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? BUSY : IDLE;
      BUSY: state_nx = last ? DONE : BUSY;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md <= '0;
      mr <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      result <= '0;
    end else if (state == IDLE && in_valid) begin
      md <= {{W{1'b0}}, mag_a};
      mr <= mag_b;
      neg <= is_signed && (multer[N-1] ^ multor[W-1]);
      acc <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= sum;
      md <= md << 1;
      mr <= mr >> 1;
      cnt <= cnt + 1'b1;
      if (last) result <= neg ? -sum : sum;
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_seq_mult_nxw.sv
// tb_seq_mult_nxw: directed self-checking bench for seq_mult_nxw at N=8, W=4
module tb_seq_mult_nxw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] multer = '0;
  logic [3:0] multor = '0;
  logic is_signed = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [11:0] result;
  logic busy;
  int pass_cnt = 0;
  int total = 0;

  seq_mult_nxw #(.N(8), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .multer(multer), .multor(multor), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic s,
                        input logic ordy, output logic [11:0] r, output int lat);
    @(negedge clk);
    multer = a;
    multor = b;
    is_signed = s;
    out_ready = ordy;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r = result;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (result !== 12'h000) $display("FAIL reset_result got %h want 000", result); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_corner;
    logic [11:0] r;
    int lat;
    run_op(8'hFF, 4'hF, 1'b0, 1'b1, r, lat);
    total++; if (r !== 12'hEF1) $display("FAIL u_corner_result got %h want ef1", r); else pass_cnt++;
    total++; if (lat !== 5) $display("FAIL u_corner_latency got %0d want 5", lat); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL u_corner_ready_in_done got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL u_corner_ready_after got %b want 1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL u_corner_valid_after got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [11:0] r;
    int lat;
    run_op(8'h80, 4'h8, 1'b1, 1'b1, r, lat);
    total++; if (r !== 12'h400) $display("FAIL s_minmin got %h want 400", r); else pass_cnt++;
    total++; if (lat !== 5) $display("FAIL s_minmin_latency got %0d want 5", lat); else pass_cnt++;
    run_op(8'h7F, 4'h8, 1'b1, 1'b1, r, lat);
    total++; if (r !== 12'hC08) $display("FAIL s_maxmin got %h want c08", r); else pass_cnt++;
    run_op(8'h00, 4'hF, 1'b1, 1'b1, r, lat);
    total++; if (r !== 12'h000) $display("FAIL s_negzero got %h want 000", r); else pass_cnt++;
    run_op(8'hFF, 4'hF, 1'b1, 1'b1, r, lat);
    total++; if (r !== 12'h001) $display("FAIL s_m1m1 got %h want 001", r); else pass_cnt++;
    run_op(8'h05, 4'hD, 1'b1, 1'b1, r, lat);
    total++; if (r !== 12'hFF1) $display("FAIL s_5xm3 got %h want ff1", r); else pass_cnt++;
    run_op(8'h80, 4'h8, 1'b0, 1'b1, r, lat);
    total++; if (r !== 12'h400) $display("FAIL u_80x8 got %h want 400", r); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [11:0] r;
    int lat;
    run_op(8'h12, 4'h3, 1'b0, 1'b0, r, lat);
    total++; if (lat !== 5) $display("FAIL bp_latency got %0d want 5", lat); else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_hold got %b want 1", out_valid); else pass_cnt++;
      total++; if (result !== 12'h036) $display("FAIL bp_result_hold got %h want 036", result); else pass_cnt++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL bp_release_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_isolation;
    @(negedge clk);
    multer = 8'h5A;
    multor = 4'h6;
    is_signed = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      multer = ~multer;
      multor = ~multor;
      is_signed = ~is_signed;
      in_valid = ~in_valid;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL iso_valid got %b want 1", out_valid); else pass_cnt++;
    total++; if (result !== 12'h21C) $display("FAIL iso_result got %h want 21c", result); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL iso_in_ready got %b want 0", in_ready); else pass_cnt++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL iso_busy_after got %b want 0", busy); else pass_cnt++;
    total++; if (result !== 12'h21C) $display("FAIL iso_result_after got %h want 21c", result); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [11:0] r;
    int lat;
    @(negedge clk);
    multer = 8'h09;
    multor = 4'h9;
    is_signed = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (result !== 12'h000) $display("FAIL rmid_result got %h want 000", result); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", in_ready); else pass_cnt++;
    run_op(8'h03, 4'h5, 1'b0, 1'b1, r, lat);
    total++; if (r !== 12'h00F) $display("FAIL rmid_fresh_result got %h want 00f", r); else pass_cnt++;
    total++; if (lat !== 5) $display("FAIL rmid_fresh_latency got %0d want 5", lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int second = -1;
    @(negedge clk);
    multer = 8'h11;
    multor = 4'h2;
    is_signed = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int t = 0; t < 16 && second < 0; t++) begin
      if (in_ready) begin
        if (first < 0) first = t;
        else second = t;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (second - first !== 6) $display("FAIL b2b_spacing got %0d want 6", second - first); else pass_cnt++;
    repeat (8) @(negedge clk);
    total++; if (result !== 12'h022) $display("FAIL b2b_result got %h want 022", result); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [3:0] b;
    logic s, o;
    logic [11:0] r, e;
    int lat, x, y;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = 4'($urandom);
      s = 1'($urandom);
      o = 1'($urandom);
      x = s ? {{24{a[7]}}, a} : {24'b0, a};
      y = s ? {{28{b[3]}}, b} : {28'b0, b};
      e = 12'(x * y);
      run_op(a, b, s, o, r, lat);
      if (!o) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
      end
      total++; if (r !== e) $display("FAIL rand_result a=%h b=%h s=%b got %h want %h", a, b, s, r, e); else pass_cnt++;
      total++; if (lat !== 5) $display("FAIL rand_latency got %0d want 5", lat); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_corner;
    test_signed;
    test_backpressure;
    test_isolation;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
